// File: rtl/pwm_rx_scheduler.sv
// Round-robin scheduler that merges NUM_CH RC pulse-width decoder results onto one write port,
// with per-channel stale detection, failsafe injection and frame-complete pulses.
// Optional sticky overrun flags: define PWM_RX_OVERRUN_EN.
module pwm_rx_scheduler #(
  parameter int unsigned clockFreq = 50000000,
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned STALE_MS  = 100
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [NUM_CH-1:0]    i_ch_en,
  input  logic [NUM_CH-1:0]    i_ready,
  input  logic [16*NUM_CH-1:0] i_value,
  output logic                 o_wr_valid,
  input  logic                 i_wr_ready,
  output logic [2:0]           o_wr_ch,
  output logic [15:0]          o_wr_data,
  output logic [NUM_CH-1:0]    o_stale,
`ifdef PWM_RX_OVERRUN_EN
  input  logic                 i_overrun_clr,
  output logic [NUM_CH-1:0]    o_overrun,
`endif
  output logic                 o_frame_pulse
);

  localparam int unsigned TickDiv = (clockFreq / 1000 > 0) ? clockFreq / 1000 : 1;
  localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [PreW-1:0] PreMax   = PreW'(TickDiv - 1);
  localparam logic [7:0]      StaleMs  = 8'(STALE_MS);
  localparam logic [15:0]     Failsafe = 16'hC000;

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StPresent = 1'b1;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return 3'(s);
  endfunction

  logic [0:0]        state_q;
  logic [2:0]        rr_ptr_q;
  logic [PreW-1:0]   pre_q;
  logic              tick;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] stale_q, stale_d;
  logic [NUM_CH-1:0] seen_q, seen_d;
  logic [15:0]       val_q [NUM_CH];
  logic [15:0]       val_d [NUM_CH];
  logic [7:0]        cnt_q [NUM_CH];
  logic [7:0]        cnt_d [NUM_CH];
  logic              frame_q, frame_d;

  logic [NUM_CH-1:0] pend_act;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] sel_mask;
  logic [NUM_CH-1:0] acc_mask;
  logic [NUM_CH-1:0] seen_nx;
  logic              any_pend;
  logic              sel_go;
  logic              accept;
  logic [2:0]        sel_idx;

  // 1 ms tick prescaler
  assign tick = (pre_q == PreMax);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign pend_act = pend_q & i_ch_en;
  assign cap      = i_ready & i_ch_en;

  // First pending enabled channel at or above rr_ptr, wrapping.
  always_comb begin
    any_pend = 1'b0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!any_pend && pend_act[wrap_idx(rr_ptr_q, i)]) begin
        any_pend = 1'b1;
        sel_idx  = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  assign sel_go   = (state_q == StIdle) && any_pend;
  assign sel_mask = sel_go ? (NUM_CH'(1) << sel_idx) : '0;
  assign accept   = (state_q == StPresent) && i_wr_ready;

  // Per-channel capture, stale timer and pending bookkeeping. Set beats the selection clear.
  always_comb begin
    pend_d  = pend_q;
    stale_d = stale_q;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      val_d[k] = val_q[k];
      cnt_d[k] = cnt_q[k];
      if (!i_ch_en[k]) begin
        pend_d[k]  = 1'b0;
        stale_d[k] = 1'b0;
        cnt_d[k]   = '0;
      end else if (i_ready[k]) begin
        val_d[k]   = i_value[16*k +: 16];
        pend_d[k]  = 1'b1;
        stale_d[k] = 1'b0;
        cnt_d[k]   = '0;
      end else begin
        if (sel_mask[k]) pend_d[k] = 1'b0;
        if (!stale_q[k] && (cnt_q[k] == StaleMs)) begin
          stale_d[k] = 1'b1;
          val_d[k]   = Failsafe;
          pend_d[k]  = 1'b1;
        end else if (tick && (cnt_q[k] != StaleMs)) begin
          cnt_d[k] = cnt_q[k] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      pend_q  <= '0;
      stale_q <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        val_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      stale_q <= stale_d;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        val_q[k] <= val_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Arbiter: the write is registered on selection and held until accepted.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      o_wr_valid <= 1'b0;
      o_wr_ch    <= '0;
      o_wr_data  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_go) begin
            o_wr_ch    <= sel_idx;
            o_wr_data  <= val_q[sel_idx];
            o_wr_valid <= 1'b1;
            rr_ptr_q   <= wrap_idx(sel_idx, 1);
            state_q    <= StPresent;
          end
        end
        StPresent: begin
          if (i_wr_ready) begin
            o_wr_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Frame tracking only ever considers currently enabled channels.
  assign acc_mask = accept ? (NUM_CH'(1) << o_wr_ch) : '0;
  assign seen_nx  = (seen_q | acc_mask) & i_ch_en;

  always_comb begin
    frame_d = 1'b0;
    seen_d  = seen_nx;
    if ((i_ch_en != '0) && (seen_nx == i_ch_en)) begin
      frame_d = 1'b1;
      seen_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      seen_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      seen_q  <= seen_d;
      frame_q <= frame_d;
    end
  end

  assign o_stale       = stale_q;
  assign o_frame_pulse = frame_q;

`ifdef PWM_RX_OVERRUN_EN
  logic [NUM_CH-1:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = i_overrun_clr ? '0 : ovr_q;
    ovr_d = ovr_d | (cap & pend_q & ~sel_mask);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign o_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_pwm_rx_scheduler.sv
// Scoreboard bench for pwm_rx_scheduler: a cycle-level behavioural model predicts writes into a
// queue that a negedge monitor drains on every accepted write, plus per-cycle status checks.
module tb_pwm_rx_scheduler;

  localparam int NCH   = 6;
  localparam int FREQ  = 10000;
  localparam int TDIV  = FREQ / 1000;
  localparam int STALE = 3;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ready;
  logic [16*NCH-1:0] value;
  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        wr_ch;
  logic [15:0]       wr_data;
  logic [NCH-1:0]    stale;
  logic              frame_pulse;
`ifdef PWM_RX_OVERRUN_EN
  logic              ovr_clr;
  logic [NCH-1:0]    overrun;
`endif

  pwm_rx_scheduler #(
    .clockFreq(FREQ),
    .NUM_CH   (NCH),
    .STALE_MS (STALE)
  ) dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_ch_en      (ch_en),
    .i_ready      (ready),
    .i_value      (value),
    .o_wr_valid   (wr_valid),
    .i_wr_ready   (wr_ready),
    .o_wr_ch      (wr_ch),
    .o_wr_data    (wr_data),
    .o_stale      (stale),
`ifdef PWM_RX_OVERRUN_EN
    .i_overrun_clr(ovr_clr),
    .o_overrun    (overrun),
`endif
    .o_frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: elapsed ms = global tick count minus tick count at last strobe.
  int m_val [NCH];
  bit m_pend [NCH];
  bit m_stale [NCH];
  bit m_seen [NCH];
  bit m_ovr [NCH];
  int m_base [NCH];
  int m_T, m_cyc, m_rr, m_cur;
  bit m_busy, m_frame;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NCH; k++) begin
        m_val[k] = 0; m_pend[k] = 0; m_stale[k] = 0; m_seen[k] = 0; m_ovr[k] = 0; m_base[k] = 0;
      end
      m_T = 0; m_cyc = 0; m_rr = 0; m_cur = 0; m_busy = 0; m_frame = 0;
      exp_q.delete();
    end else begin : step_model
      int  tnext, sel, c;
      bit  acc, all_seen;
      tnext = m_T + (((m_cyc % TDIV) == TDIV - 1) ? 1 : 0);
      acc   = m_busy && wr_ready;
      sel   = -1;
      if (!m_busy) begin
        for (int off = 0; off < NCH; off++) begin
          c = (m_rr + off) % NCH;
          if (sel < 0 && ch_en[c] && m_pend[c]) sel = c;
        end
      end
`ifdef PWM_RX_OVERRUN_EN
      for (int k = 0; k < NCH; k++) begin
        if (ch_en[k] && ready[k] && m_pend[k] && sel != k) m_ovr[k] = 1;
        else if (ovr_clr) m_ovr[k] = 0;
      end
`endif
      if (acc) begin
        m_busy = 0;
        m_seen[m_cur] = 1;
      end
      if (sel >= 0) begin
        exp_q.push_back('{ch: 3'(sel), data: 16'(m_val[sel])});
        m_busy = 1; m_cur = sel; m_pend[sel] = 0; m_rr = (sel + 1) % NCH;
      end
      for (int k = 0; k < NCH; k++) begin
        if (!ch_en[k]) begin
          m_pend[k] = 0; m_stale[k] = 0; m_base[k] = tnext;
        end else if (ready[k]) begin
          m_val[k] = int'(value[16*k +: 16]); m_pend[k] = 1; m_stale[k] = 0; m_base[k] = tnext;
        end else if (!m_stale[k] && (m_T - m_base[k]) >= STALE) begin
          m_stale[k] = 1; m_val[k] = 'hC000; m_pend[k] = 1;
        end
      end
      all_seen = (ch_en != '0);
      for (int k = 0; k < NCH; k++) begin
        if (!ch_en[k]) m_seen[k] = 0;
        else if (!m_seen[k]) all_seen = 0;
      end
      m_frame = all_seen;
      if (all_seen) for (int k = 0; k < NCH; k++) m_seen[k] = 0;
      m_T = tnext;
      m_cyc++;
    end
  end

  // Monitor: status every cycle, scoreboard pop on each accepted write.
  always @(negedge clk) begin : monitor
    logic [NCH-1:0] es;
    wr_t e;
    for (int k = 0; k < NCH; k++) es[k] = m_stale[k];
    chk("wr_valid", 32'(wr_valid), 32'(m_busy));
    chk("stale", 32'(stale), 32'(es));
    chk("frame_pulse", 32'(frame_pulse), 32'(m_frame));
`ifdef PWM_RX_OVERRUN_EN
    for (int k = 0; k < NCH; k++) es[k] = m_ovr[k];
    chk("overrun", 32'(overrun), 32'(es));
`endif
    if (!resetn) begin
      chk("reset_wr_ch", 32'(wr_ch), 32'd0);
      chk("reset_wr_data", 32'(wr_data), 32'd0);
    end else if (wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_ch", 32'(wr_ch), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_ch", 32'(wr_ch), 32'(e.ch));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int ch, input logic [15:0] v);
    ready = '0;
    ready[ch] = 1'b1;
    value[16*ch +: 16] = v;
    step(1);
    ready = '0;
  endtask

  initial begin
    int mode;
    ch_en    = '1;
    ready    = '0;
    value    = '0;
    wr_ready = 1'b1;
`ifdef PWM_RX_OVERRUN_EN
    ovr_clr  = 1'b0;
`endif
    step(3);
    resetn = 1'b1;

    // Single channel and all-channel round-robin
    strobe(2, 16'd1500);
    step(4);
    for (int k = 0; k < NCH; k++) value[16*k +: 16] = 16'(1000 + k);
    ready = '1;
    step(1);
    ready = '0;
    step(16);

    // Backpressure: 1300 overwrites 1200 while the port is stalled
    wr_ready = 1'b0;
    strobe(3, 16'd777);
    step(3);
    strobe(1, 16'd1200);
    step(5);
    strobe(1, 16'd1300);
`ifdef PWM_RX_OVERRUN_EN
    step(5);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
`endif
    step(10);
    wr_ready = 1'b1;
    step(10);

    // Quiet period: every enabled channel goes stale and emits one failsafe write
    ch_en = 6'b010000;
    step(60);
    strobe(4, 16'd1500);
    ch_en = '1;
    step(80);

    // Disable ch0 while it is pending
    wr_ready = 1'b0;
    strobe(5, 16'd42);
    strobe(0, 16'd43);
    ch_en[0] = 1'b0;
    step(2);
    wr_ready = 1'b1;
    for (int k = 1; k < NCH; k++) strobe(k, 16'(2000 + k));
    step(20);
    ch_en = '1;

    // Randomised traffic in busy, sparse and quiet blocks
    for (int blk = 0; blk < 16; blk++) begin
      mode = $urandom_range(2, 0);
      if ($urandom_range(3, 0) == 0) ch_en = NCH'($urandom);
      else ch_en = '1;
      for (int cyc = 0; cyc < 150; cyc++) begin
        for (int k = 0; k < NCH; k++) begin
          ready[k] = (mode == 0) ? ($urandom_range(5, 0) == 0)
                   : (mode == 1) ? ($urandom_range(63, 0) == 0) : 1'b0;
          value[16*k +: 16] = 16'($urandom);
        end
        wr_ready = ($urandom_range(3, 0) != 0);
`ifdef PWM_RX_OVERRUN_EN
        ovr_clr = ($urandom_range(15, 0) == 0);
`endif
        step(1);
      end
    end
    ready    = '0;
    wr_ready = 1'b1;
    ch_en    = '1;
`ifdef PWM_RX_OVERRUN_EN
    ovr_clr  = 1'b0;
`endif
    step(10);

    // Reset while a write is being presented
    wr_ready = 1'b0;
    strobe(3, 16'd999);
    step(2);
    resetn = 1'b0;
    step(3);
    resetn = 1'b1;
    wr_ready = 1'b1;
    strobe(2, 16'd1234);
    step(10);

    // Drain: disable everything so nothing new is scheduled
    ch_en = '0;
    step(10);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_rx_scheduler.md
Name: pwm_rx_scheduler

Overview:
- Collects results from NUM_CH parallel RC-receiver pulse-width decoders and shares one register-write port between them.
- Each decoder channel reports with a one-cycle ready strobe and a 16-bit value.
- Channels are served round-robin over a valid/ready port that feeds the host register bank.
- Detects channels that stop reporting, injects a failsafe code for them, and signals when a full frame of enabled channels has been written.

Parameters:
- clockFreq, 50000000, i_clk frequency in Hz; the ms tick divider is clockFreq/1000.
- NUM_CH, 6, number of decoder channels; legal range 1..8.
- STALE_MS, 100, ms without a ready strobe before a channel is declared stale; legal range 1..255.

Ports:
- i_clk  in  1  clock.
- i_resetn  in  1  reset.
- i_ch_en  in  NUM_CH  per-channel enable.
- i_ready  in  NUM_CH  per-channel result strobe, one cycle wide.
- i_value  in  16*NUM_CH  channel k value is on bits [16k+15:16k]; bit15 is the decoder error flag.
- o_wr_valid  out  1  write request.
- i_wr_ready  in  1  write accept.
- o_wr_ch  out  3  channel index of the current write.
- o_wr_data  out  16  value of the current write.
- o_stale  out  NUM_CH  channel is currently stale.
- o_frame_pulse  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: reset i_resetn, asynchronous, active-low; clock i_clk. While reset is asserted all outputs are 0. Also cleared: pend, seen, rr_ptr, all ms counters and the tick prescaler. A write that is in flight when reset asserts is dropped.
- Capture: i_ready[k] & i_ch_en[k] loads val_q[k] from the channel slice and sets pend[k] on the next edge. If pend[k] is already set, latest value wins (overwrite). Values are passed through unmodified, including bit15 error codes.
- Arbiter FSM, two states: IDLE, PRESENT.
  - IDLE: if any pend bit is set, select the first pending channel k searching upward from rr_ptr with wrap.
  - On selection: load o_wr_ch=k and o_wr_data=val_q[k], assert o_wr_valid, clear pend[k], set rr_ptr=(k+1) mod NUM_CH, go to PRESENT.
  - PRESENT: hold o_wr_valid, o_wr_ch and o_wr_data stable until i_wr_ready=1. On the accepting edge, drop o_wr_valid and return to IDLE.
- Timing: capture-to-valid latency is 2 cycles with the port idle and no contention. Peak rate is one write per 2 cycles.
- Simultaneous capture and selection of the same channel: the selected write carries the old val_q. The new value is captured and pend[k] stays 1.
- Stale detection:
  - A prescaler generates a 1 ms tick. Each channel has an 8-bit ms counter, reset by any accepted i_ready[k].
  - When the counter reaches STALE_MS and o_stale[k]=0: set o_stale[k], load val_q[k]=16'hC000, set pend[k]. The counter then holds.
  - The failsafe write is issued exactly once per stale episode.
  - The next i_ready[k] clears o_stale[k] and restarts the counter.
  - If i_ready[k] and the stale threshold occur in the same cycle, the ready wins.
- Disabled channel (i_ch_en[k]=0): pend[k], o_stale[k] and the counter are held at 0, and strobes are ignored. If the channel is disabled while in PRESENT, the in-flight write still completes.
- Frame tracking:
  - seen[k] is set when a write for channel k is accepted; both real and failsafe writes count.
  - When (seen & i_ch_en)==i_ch_en and i_ch_en!=0: o_frame_pulse=1 for one cycle and seen is cleared.
  - All channels disabled: no frame pulses.

Optional Feature:
- PWM_RX_OVERRUN_EN defined:
  - Adds input i_overrun_clr (1 bit) and output o_overrun (NUM_CH bits).
  - o_overrun[k] is a sticky flag, set when a capture on channel k occurs while pend[k] is already set and channel k is not being selected in that cycle.
  - i_overrun_clr clears all flags; a set in the same cycle wins.
- Macro undefined: neither port exists, and overwrite still occurs silently.

Test Plan:
- Single channel: i_ready[2] with value 1500 and i_wr_ready=1 -> o_wr_valid 2 cycles later, o_wr_ch=2, o_wr_data=1500, valid high exactly 1 cycle.
- Round-robin: all 6 channels strobed in the same cycle with values 1000+k, ready tied high -> writes in order ch0..ch5 at 2-cycle spacing, then o_frame_pulse; re-strobe after rr_ptr=3 -> order ch3,ch4,ch5,ch0,ch1,ch2.
- Backpressure: i_wr_ready=0 for 20 cycles while ch1 is re-strobed with 1200 then 1300 -> first write data stays constant for the whole stall; the next write for ch1 carries 1300, and 1200 is never written.
- Stale: ch4 enabled with no strobes, STALE_MS=3 -> after 3 ms: o_stale[4]=1 and exactly one write of 16'hC000 on ch4; a later strobe with 1500 clears o_stale[4] and writes 1500.
- Enable and reset: clear i_ch_en[0] while pend[0]=1 -> no ch0 write and frame completes on the remaining channels; assert i_resetn low during PRESENT -> o_wr_valid drops immediately and all state is clear after release.
- With PWM_RX_OVERRUN_EN: two ch5 strobes while the port is stalled -> o_overrun[5]=1 until i_overrun_clr is pulsed.
